mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 10 +
 rtl/mem_return_pipe.sv | 46 ++++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM states, requester IDs, defaults and address helper
package mem_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE} state_t;
  typedef enum logic {REQ_I, REQ_D} req_id_t;
  localparam int DEF_LATENCY = 4;
  localparam int DEF_BURST = 8;
  function automatic logic [15:0] block_base(input logic [15:0] a);
    return a & 16'hFFF0;
  endfunction
endpackage

// File: rtl/mem_return_pipe.sv
// mem_return_pipe: LATENCY-deep shift of in-flight read valid, word index and owner
module mem_return_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [IW-1:0] in_idx,
  input  req_id_t       in_owner,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output req_id_t       out_owner
);
  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0][IW-1:0] idx_q, idx_d;
  logic [LATENCY-1:0] owner_q, owner_d;
  // shift every stage one step toward the output each cycle
  always_comb begin
    valid_d[0] = in_valid;
    idx_d[0] = in_idx;
    owner_d[0] = in_owner;
    for (int j = 1; j < LATENCY; j++) begin
      valid_d[j] = valid_q[j-1];
      idx_d[j] = idx_q[j-1];
      owner_d[j] = owner_q[j-1];
    end
  end
  // reset drops every in-flight return so late memory data is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      idx_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q <= idx_d;
      owner_q <= owner_d;
    end
  end
  assign out_valid = valid_q[LATENCY-1];
  assign out_idx = idx_q[LATENCY-1];
  assign out_owner = req_id_t'(owner_q[LATENCY-1]);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: I/D cache arbiter for a shared multi-cycle memory (MEM_ARBITER_RR_EN enables round-robin)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int BURST = DEF_BURST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic [15:0]              i_addr,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [15:0]              d_addr,
  input  logic [15:0]              d_wdata,
  output logic                     mem_enable,
  output logic                     mem_wr,
  output logic [15:0]              mem_addr,
  output logic [15:0]              mem_wdata,
  input  logic [15:0]              mem_rdata,
  output logic [15:0]              rdata,
  output logic [$clog2(BURST)-1:0] word_idx,
  output logic                     i_rvalid,
  output logic                     d_rvalid,
  output logic                     i_done,
  output logic                     d_done,
  output logic                     busy
);
  localparam int IW = $clog2(BURST);
  localparam logic [IW-1:0] K_LAST = IW'(BURST - 1);
  state_t state_q, state_d;
  req_id_t owner_q, owner_d, win, p_owner;
  logic [IW-1:0] k_q, k_d, p_idx;
  logic en_q, en_d, wr_q, wr_d, p_valid, rd_last, grant;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
  assign grant = (state_q == S_IDLE) && (i_req || d_req);
`ifdef MEM_ARBITER_RR_EN
  req_id_t last_q, last_d;
  assign win = (i_req && d_req) ? ((last_q == REQ_D) ? REQ_I : REQ_D) : (d_req ? REQ_D : REQ_I);
  assign last_d = grant ? win : last_q;
  // remember the most recent grant; starting at I lets D win the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= REQ_I;
    else last_q <= last_d;
  end
`else
  assign win = d_req ? REQ_D : REQ_I;
`endif
  // next state and next memory-port values; the port is zero unless issuing or writing
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    owner_d = owner_q;
    en_d = 1'b0;
    wr_d = 1'b0;
    addr_d = '0;
    wdata_d = '0;
    case (state_q)
      S_IDLE: if (grant) begin
        owner_d = win;
        en_d = 1'b1;
        k_d = '0;
        if (win == REQ_D && d_we) begin
          state_d = S_WRITE;
          wr_d = 1'b1;
          addr_d = d_addr;
          wdata_d = d_wdata;
        end else begin
          state_d = S_ISSUE;
          addr_d = block_base(win == REQ_D ? d_addr : i_addr);
        end
      end
      S_ISSUE: if (k_q == K_LAST) state_d = S_DRAIN;
      else begin
        k_d = k_q + 1'b1;
        en_d = 1'b1;
        addr_d = addr_q + 16'd2;
      end
      S_DRAIN: if (rd_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // FSM and registered memory-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q <= '0;
      owner_q <= REQ_I;
      en_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      owner_q <= owner_d;
      en_q <= en_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  mem_return_pipe #(.LATENCY(LATENCY), .IW(IW)) u_pipe (
    .clk(clk),
    .rst(rst),
    .in_valid(en_q && !wr_q),
    .in_idx(k_q),
    .in_owner(owner_q),
    .out_valid(p_valid),
    .out_idx(p_idx),
    .out_owner(p_owner)
  );
  assign rd_last = p_valid && (p_idx == K_LAST);
  assign mem_enable = en_q;
  assign mem_wr = wr_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata = p_valid ? mem_rdata : '0;
  assign word_idx = p_valid ? p_idx : '0;
  assign i_rvalid = p_valid && (p_owner == REQ_I);
  assign d_rvalid = p_valid && (p_owner == REQ_D);
  assign i_done = rd_last && (p_owner == REQ_I);
  assign d_done = (state_q == S_WRITE) || (rd_last && (p_owner == REQ_D));
  assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (LATENCY=4, BURST=8)
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic i_req = 0, d_req = 0, d_we = 0;
  logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic mem_enable, mem_wr, i_rvalid, d_rvalid, i_done, d_done, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, rdata;
  logic [2:0] word_idx;
  logic [3:0][15:0] hist = '0;
  int n_run = 0, n_fail = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rdata(rdata),
    .word_idx(word_idx), .i_rvalid(i_rvalid), .d_rvalid(d_rvalid), .i_done(i_done),
    .d_done(d_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // memory model: data for the address seen 4 cycles ago, scrambled
  always @(posedge clk) hist <= {hist[2:0], mem_addr};
  assign mem_rdata = hist[3] ^ 16'hA5A5;

  task automatic test_reset();
    #2;
    n_run++;
    if ({mem_enable, mem_wr, mem_addr, mem_wdata, rdata, word_idx, i_rvalid, d_rvalid, i_done, d_done, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b wr=%b addr=%h wdata=%h rdata=%h idx=%0d busy=%b, want all 0",
               mem_enable, mem_wr, mem_addr, mem_wdata, rdata, word_idx, busy);
    end
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    n_run++;
    if ({busy, mem_enable} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b en=%b, want 0 0", busy, mem_enable);
    end
  endtask

  task automatic test_read_burst(input string nm, input bit use_d, input logic [15:0] a,
                                 input logic [15:0] base, input int drop_at);
    logic [41:0] got, exp;
    logic en, rv;
    int k;
    if (use_d) begin d_req = 1; d_we = 0; d_addr = a; end
    else begin i_req = 1; i_addr = a; end
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      en = (c >= 1) && (c <= 8);
      rv = (c >= 5) && (c <= 12);
      k = c - 5;
      exp = {en, 1'b0, en ? base + 16'(2 * (c - 1)) : 16'h0,
             rv && !use_d, rv && use_d, rv ? 3'(k) : 3'd0,
             rv ? ((base + 16'(2 * k)) ^ 16'hA5A5) : 16'h0,
             (c == 12) && !use_d, (c == 12) && use_d, c <= 12};
      got = {mem_enable, mem_wr, mem_addr, i_rvalid, d_rvalid, word_idx, rdata, i_done, d_done, busy};
      n_run++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h, want %h", nm, c, got, exp);
      end
      if (c == drop_at || c == 12) begin
        if (use_d) d_req = 0;
        else i_req = 0;
      end
    end
  endtask

  task automatic test_both();
    i_req = 1; i_addr = 16'h0100; d_req = 1; d_we = 0; d_addr = 16'h0200;
    for (int c = 1; c <= 26; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        n_run++;
        if ({mem_enable, mem_addr} !== {1'b1, 16'h0200}) begin
          n_fail++;
          $display("FAIL both_d_first: got en=%b addr=%h, want 1 0200", mem_enable, mem_addr);
        end
      end
      if (c == 12) begin
        n_run++;
        if ({d_done, i_done} !== 2'b10) begin
          n_fail++;
          $display("FAIL both_d_done: got d_done=%b i_done=%b, want 1 0", d_done, i_done);
        end
        d_req = 0;
      end
      if (c == 13) begin
        n_run++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL both_gap: got busy=%b, want 0", busy);
        end
      end
      if (c == 14) begin
        n_run++;
        if ({mem_enable, mem_addr} !== {1'b1, 16'h0100}) begin
          n_fail++;
          $display("FAIL both_i_second: got en=%b addr=%h, want 1 0100", mem_enable, mem_addr);
        end
      end
      if (c == 18) begin
        n_run++;
        if ({i_rvalid, d_rvalid, word_idx} !== {2'b10, 3'd0}) begin
          n_fail++;
          $display("FAIL both_i_word0: got irv=%b drv=%b idx=%0d, want 1 0 0", i_rvalid, d_rvalid, word_idx);
        end
      end
      if (c == 25) begin
        n_run++;
        if ({i_done, d_done} !== 2'b10) begin
          n_fail++;
          $display("FAIL both_i_done: got i_done=%b d_done=%b, want 1 0", i_done, d_done);
        end
        i_req = 0;
      end
    end
  endtask

  task automatic test_write(input logic [15:0] a, input logic [15:0] wd);
    d_req = 1; d_we = 1; d_addr = a; d_wdata = wd;
    @(posedge clk); #1;
    n_run++;
    if ({mem_enable, mem_wr, mem_addr, mem_wdata, d_done, i_done, busy} !== {2'b11, a, wd, 3'b101}) begin
      n_fail++;
      $display("FAIL write_cycle1: got en=%b wr=%b addr=%h wdata=%h d_done=%b busy=%b, want 1 1 %h %h 1 1",
               mem_enable, mem_wr, mem_addr, mem_wdata, d_done, busy, a, wd);
    end
    d_req = 0; d_we = 0;
    @(posedge clk); #1;
    n_run++;
    if ({busy, mem_enable, mem_wr, d_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL write_cycle2: got busy=%b en=%b wr=%b d_done=%b, want 0 0 0 0", busy, mem_enable, mem_wr, d_done);
    end
  endtask

  task automatic test_rr();
    logic [15:0] exp_addr;
    bit exp_i, seen;
`ifdef MEM_ARBITER_RR_EN
    exp_addr = 16'h0700; exp_i = 1;
`else
    exp_addr = 16'h0900; exp_i = 0;
`endif
    test_write(16'h0500, 16'h1234);
    i_req = 1; i_addr = 16'h0704; d_req = 1; d_we = 0; d_addr = 16'h0908;
    @(posedge clk); #1;
    n_run++;
    if (mem_addr !== exp_addr) begin
      n_fail++;
      $display("FAIL rr_grant: got addr=%h, want %h", mem_addr, exp_addr);
    end
    seen = 0;
    for (int c = 2; c <= 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (i_done || d_done) begin
        seen = 1;
        n_run++;
        if ({i_done, d_done} !== {exp_i, !exp_i}) begin
          n_fail++;
          $display("FAIL rr_owner_done: got i_done=%b d_done=%b, want %b %b", i_done, d_done, exp_i, !exp_i);
        end
        i_req = 0; d_req = 0;
      end
    end
    if (!seen) begin
      n_run++; n_fail++;
      $display("FAIL rr_timeout: got no done within 20 cycles, want one");
      i_req = 0; d_req = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    i_req = 1; i_addr = 16'h0040;
    for (int c = 1; c <= 6; c++) begin @(posedge clk); #1; end
    rst = 1;
    #1;
    n_run++;
    if ({mem_enable, mem_wr, mem_addr, mem_wdata, rdata, word_idx, i_rvalid, d_rvalid, i_done, d_done, busy} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got en=%b addr=%h rdata=%h idx=%0d irv=%b busy=%b, want all 0",
               mem_enable, mem_addr, rdata, word_idx, i_rvalid, busy);
    end
    i_req = 0;
    @(posedge clk); #1 rst = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_run++;
      if ({i_rvalid, d_rvalid, i_done, d_done, busy, rdata} !== '0) begin
        n_fail++;
        $display("FAIL midreset_late %0d: got irv=%b idone=%b busy=%b rdata=%h, want 0", c, i_rvalid, i_done, busy, rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_burst("i_read", 0, 16'h0013, 16'h0010, 0);
    test_both();
    test_write(16'h2002, 16'hBEEF);
    test_rr();
    test_read_burst("wrap", 0, 16'hFFF4, 16'hFFF0, 0);
    test_read_burst("d_drop", 1, 16'h3456, 16'h3450, 3);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
